regfile_multiport: RTL
======================

# regfile_multiport

Parametrised register file for the LumosRV cores, generalising the fixed 32×32, two-read-port register file in width, depth and read-port count. Adds an optional write-to-read bypass, a per-register pending-write scoreboard for pipeline hazard detection, and a single addressable debug read port. It sits between decode (read and issue), writeback (write and clear), and the debug/trace logic.

## Interface
- `XLEN`, 32: data width of each register.
- `NREGS`, 32: register count; power of two, at least 2.
- `NRD`, 2: number of architectural read ports, at least 1.
- `AW`, $clog2(NREGS): address width; derived, never overridden.

- `clk`  in  1  clock; all state updates on its rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `ra`  in  NRD*AW  read addresses; port k occupies bits [k*AW +: AW].
- `rd`  out  NRD*XLEN  read data; port k occupies bits [k*XLEN +: XLEN].
- `rd_busy`  out  NRD  port k's register has a pending write.
- `we`  in  1  write enable.
- `wa`  in  AW  write address.
- `wd`  in  XLEN  write data.
- `sb_set`  in  1  issue: mark `sb_addr` pending.
- `sb_addr`  in  AW  scoreboard set address.
- `dbg_addr`  in  AW  debug read address.
- `dbg_data`  out  XLEN  debug read data; never bypassed.
- `busy_cnt`  out  AW+1  number of registers currently pending.

## Operation
- Storage: NREGS×XLEN array plus an NREGS-bit `pend` vector.
- Register 0 is hardwired to zero:
  - reads of address 0 always return 0;
  - writes to address 0 are dropped;
  - `sb_set` to address 0 is ignored, so `pend[0]` is always 0.
- Write: when `we` is high and `wa` is nonzero, `wd` lands in `wa` at the edge. The same edge clears `pend[wa]`.
- Scoreboard set: when `sb_set` is high and `sb_addr` is nonzero, `pend[sb_addr]` is set at the edge.
- Set and clear on the same address in the same cycle: set wins, and `pend` stays 1. This models a younger instruction reclaiming the register.
- Reads are combinational for every port k:
  - `rd[k] = array[ra[k]]`;
  - `rd_busy[k] = pend[ra[k]]`, subject to bypass below.
- `dbg_data = array[dbg_addr]`, combinational. It never sees bypass.
- `busy_cnt` is a registered popcount of `pend`.
  - It is updated incrementally: +1 on an effective set of a non-pending register, −1 on an effective clear of a pending register, net 0 when both occur on different addresses.
  - It always equals the popcount of `pend`.
- Reset clears the array, `pend` and `busy_cnt`. All outputs read 0 while `rst` is asserted.

## Timing
- Write-to-read latency: 1 cycle without bypass, 0 cycles with bypass.
- Scoreboard set is visible on `rd_busy` the cycle after `sb_set`.
- Reads of unchanged registers are stable combinationally within the same cycle.
- Asserting `rst` mid-cycle clears state immediately, regardless of the clock.
  - A write or set coinciding with deassertion of `rst` is discarded only if `rst` is still high at that edge.
- No handshake back-pressure: the block accepts every write and set each cycle.

## Configuration
- `RF_BYPASS_EN` defined: for each port k with `we` high, `wa` nonzero and `ra[k] == wa`:
  - `rd[k] = wd` in the same cycle;
  - `rd_busy[k] = 0`, unless `sb_set` targets the same address that cycle, in which case it is 1.
- `RF_BYPASS_EN` undefined: `rd` and `rd_busy` reflect registered state only. A decode stage reading `wa` in the write cycle sees the old value and busy = 1.
- `dbg_data` and `busy_cnt` are identical in both builds.

## Test plan
- Reset: write 0xDEADBEEF to x5, then pulse `rst` asynchronously between edges -> `rd`, `dbg_data` and `busy_cnt` read 0 immediately, before the next edge.
- Basic write/read (NRD=3): write 0x1234 to x7, then `ra` = {7, 0, 31} -> `rd` = {0x1234, 0, 0}. A write of 0xFFFF to x0 leaves x0 = 0.
- Bypass: in the same cycle as write of 0xA5A5 to x9, set `ra[0]` = 9 -> with the macro `rd[0]` = 0xA5A5 and `rd_busy[0]` = 0; without it, the old value and busy = 1.
- Scoreboard: `sb_set` x3 at cycle 1 -> `rd_busy` on x3 = 1 and `busy_cnt` = 1 at cycle 2. Write x3 with `sb_set` x3 in the same cycle -> `pend[3]` stays 1 and `busy_cnt` = 1.
- Counter: set x1, x2, x4 on consecutive cycles, then write x2 while setting x6 -> `busy_cnt` sequence 1, 2, 3, 3; `sb_set` to x0 leaves the count unchanged.
- Parameter sweep: XLEN=64, NREGS=16, NRD=4 -> all ports independent, and `busy_cnt` saturates at 15 with every nonzero register pending.

Source files
------------

// File: rtl/regfile_multiport.sv
// Parametrised register file: NRD combinational read ports, one write port, pending-write
// scoreboard with a registered busy count, and an unbypassed debug port. Define RF_BYPASS_EN for write-to-read bypass.
module regfile_multiport #(
    parameter  int XLEN  = 32,
    parameter  int NREGS = 32,
    parameter  int NRD   = 2,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   ra,
    output logic [NRD*XLEN-1:0] rd,
    output logic [NRD-1:0]      rd_busy,
    input  logic                we,
    input  logic [AW-1:0]       wa,
    input  logic [XLEN-1:0]     wd,
    input  logic                sb_set,
    input  logic [AW-1:0]       sb_addr,
    input  logic [AW-1:0]       dbg_addr,
    output logic [XLEN-1:0]     dbg_data,
    output logic [AW:0]         busy_cnt
);

    logic [XLEN-1:0]  r_mem [NREGS];
    logic [NREGS-1:0] r_pend;
    logic [AW:0]      r_busy_cnt;

    logic             w_wr_eff;
    logic             w_set_eff;
    logic             w_set_new;
    logic             w_clr_old;
    logic [AW:0]      w_cnt_next;

    // Register 0 is hardwired: writes and sets aimed at it have no effect.
    assign w_wr_eff  = we && (wa != '0);
    assign w_set_eff = sb_set && (sb_addr != '0);
    assign w_set_new = w_set_eff && !r_pend[sb_addr];
    assign w_clr_old = w_wr_eff && r_pend[wa] && !(w_set_eff && (sb_addr == wa));

    // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        w_cnt_next = r_busy_cnt;
        if (w_set_new) begin
            w_cnt_next = w_cnt_next + (AW+1)'(1);
        end
        if (w_clr_old) begin
            w_cnt_next = w_cnt_next - (AW+1)'(1);
        end
    end

    // NOTE: the array sits on the async reset because clearing it is architectural behaviour.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_mem[i] <= '0;
            end
            r_pend     <= '0;
            r_busy_cnt <= '0;
        end else begin
            if (w_wr_eff) begin
                r_mem[wa]  <= wd;
                r_pend[wa] <= 1'b0;
            end
            // NOTE: non-blocking updates; the set comes last so it overrides a same-address clear.
            if (w_set_eff) begin
                r_pend[sb_addr] <= 1'b1;
            end
            r_busy_cnt <= w_cnt_next;
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0] w_ra;
        assign w_ra = ra[k*AW +: AW];
`ifdef RF_BYPASS_EN
        logic w_hit;
        // Bypass is gated by rst so every output reads 0 while reset is held.
        assign w_hit = w_wr_eff && !rst && (w_ra == wa);
        assign rd[k*XLEN +: XLEN] = w_hit ? wd : r_mem[w_ra];
        assign rd_busy[k]         = w_hit ? (w_set_eff && (sb_addr == wa)) : r_pend[w_ra];
`else
        assign rd[k*XLEN +: XLEN] = r_mem[w_ra];
        assign rd_busy[k]         = r_pend[w_ra];
`endif
    end

    assign dbg_data = r_mem[dbg_addr];
    assign busy_cnt = r_busy_cnt;

endmodule
